// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall controller.
// TUSE_NONE marks an operand the D-stage instruction does not read.
// The mult/div busy lengths are the default timer loads.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE      = 2'd3;
  localparam int         MD_MULT_CYCLES = 5;
  localparam int         MD_DIV_CYCLES  = 10;
  localparam logic       MD_OP_MULT     = 1'b0;
  localparam logic       MD_OP_DIV      = 1'b1;

  // A D-stage operand must wait when a younger-stage producer of the same
  // register delivers its result later than the operand is consumed.
  // The TUSE_NONE test is redundant because Tnew never exceeds 2. It is kept
  // so the intent is visible at the comparator.
  function automatic logic operand_stall(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    return (addr != 5'd0) && (tuse != TUSE_NONE) &&
           (((addr == e_wa) && (e_tnew > tuse)) ||
            ((addr == m_wa) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the stall controller.
// There is no valid/ready handshake. Every field is a same-cycle level.
// The datapath (master) presents the D/E/M hazard descriptors and the md start
// pulse. The controller (slave) answers combinationally in that same cycle with
// the enables and the bubble request.
interface hazard_stall_ctrl_if;
  logic [4:0] d_rs_addr;
  logic [4:0] d_rt_addr;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_is_md;
  logic [4:0] e_wa;
  logic [1:0] e_tnew;
  logic [4:0] m_wa;
  logic [1:0] m_tnew;
  logic       e_md_start;
  logic       e_md_op;
  logic       pc_we;
  logic       fd_we;
  logic       de_clr;
  logic       md_busy;

  modport master (
    output d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_is_md,
    output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
    input  pc_we, fd_we, de_clr, md_busy
  );

  modport slave (
    input  d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, d_is_md,
    input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_op,
    output pc_we, fd_we, de_clr, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_timer.sv
// Multiply/divide busy timer. The timer loads the op latency on a start pulse
// while idle, then counts down to zero. A start pulse that arrives while the
// timer is counting is ignored.
module hazard_stall_ctrl_md_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_op,
  output logic md_busy
);

  logic [CNT_W-1:0] md_cnt_d;
  logic [CNT_W-1:0] md_cnt_q;

  // Next count: decrement while running, load on a start pulse while idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end else if (md_start) begin
      unique case (md_op)
        MD_OP_MULT: md_cnt_d = CNT_W'(MULT_CYCLES);
        MD_OP_DIV:  md_cnt_d = CNT_W'(DIV_CYCLES);
        default:    md_cnt_d = '0;
      endcase
    end
  end

  // Count register. Reset wins over a coincident start pulse.
  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  // Busy is masked during reset so the output is clean in the same cycle.
  always_comb begin
    md_busy = (md_cnt_q != '0) && !reset;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller for the five-stage MIPS core.
// The controller compares D-stage Tuse against E/M-stage Tnew and serialises
// HI/LO users behind an in-flight mult/div. It drives the PC and F/D write
// enables and the D/E bubble clear.
// Optional feature macro: STALL_STAT_EN adds a wrapping 32-bit stall counter
// on the stall_cnt port.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
`ifdef STALL_STAT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  logic md_busy;
  logic rs_stall;
  logic rt_stall;
  logic md_stall;
  logic stall;

  hazard_stall_ctrl_md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .md_start (hz.e_md_start),
    .md_op    (hz.e_md_op),
    .md_busy  (md_busy)
  );

  // Hazard comparators and output mux. All are combinational from the current
  // inputs. Reset forces the pipeline to run freely.
  always_comb begin
    rs_stall = operand_stall(hz.d_rs_addr, hz.d_rs_tuse, hz.e_wa, hz.e_tnew,
                             hz.m_wa, hz.m_tnew);
    rt_stall = operand_stall(hz.d_rt_addr, hz.d_rt_tuse, hz.e_wa, hz.e_tnew,
                             hz.m_wa, hz.m_tnew);
    md_stall = hz.d_is_md && (md_busy || hz.e_md_start);
    stall    = (rs_stall || rt_stall || md_stall) && !reset;
    hz.pc_we   = !stall;
    hz.fd_we   = !stall;
    hz.de_clr  = stall;
    hz.md_busy = md_busy;
  end

`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;

  // Count stall cycles. The counter wraps naturally at 32 bits.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl.
// Inputs change on the falling edge. Outputs are checked 1ns later.
// Observed outputs are packed as {pc_we, fd_we, de_clr, md_busy}.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam logic [3:0] RUN      = 4'b1100;
  localparam logic [3:0] STALL    = 4'b0010;
  localparam logic [3:0] STALL_MD = 4'b0011;
  localparam logic [3:0] RUN_BUSY = 4'b1101;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [3:0] exp_q[$];

  hazard_stall_ctrl_if hz();

`ifdef STALL_STAT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .hz        (hz)
`ifdef STALL_STAT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // A start pulse while the md unit is busy must never be issued.
  always @(negedge clk) begin
    #2;
    assert (!(!reset && hz.e_md_start && hz.md_busy)) else begin
      miscompares++;
      $error("FAIL md_start_while_busy observed=1 expected=0");
    end
  end

  // Driver tasks.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    hz.d_rs_addr  = 5'd0;
    hz.d_rt_addr  = 5'd0;
    hz.d_rs_tuse  = TUSE_NONE;
    hz.d_rt_tuse  = TUSE_NONE;
    hz.d_is_md    = 1'b0;
    hz.e_wa       = 5'd0;
    hz.e_tnew     = 2'd0;
    hz.m_wa       = 5'd0;
    hz.m_tnew     = 2'd0;
    hz.e_md_start = 1'b0;
    hz.e_md_op    = MD_OP_MULT;
  endtask

  task automatic rs_load_use();
    hz.d_rs_addr = 5'd8;
    hz.d_rs_tuse = 2'd0;
    hz.e_wa      = 5'd8;
    hz.e_tnew    = 2'd2;
  endtask

  // Scoreboard check: pops the expected value pushed just before.
  task automatic chk(input string tag);
    logic [3:0] obs;
    logic [3:0] exp;
    #1;
    obs = {hz.pc_we, hz.fd_we, hz.de_clr, hz.md_busy};
    exp = exp_q.pop_front();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] exp);
    exp_q.push_back(exp);
    chk(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();

    // Reset forces free-running outputs even with hazards and a start pulse.
    nxt(); rs_load_use(); hz.d_is_md = 1'b1; hz.e_md_start = 1'b1;
    expect_out("reset_force", RUN);
    nxt(); reset = 1'b0; idle();
    expect_out("reset_prio_no_busy", RUN);
`ifdef STALL_STAT_EN
    vectors++;
    assert (stall_cnt === 32'd0) else begin
      miscompares++;
      $error("FAIL stall_cnt_reset observed=%0d expected=0", stall_cnt);
    end
`endif

    // Load-use from the E stage.
    nxt(); rs_load_use();
    expect_out("load_use_e", STALL);
    nxt(); hz.e_tnew = 2'd0;
    expect_out("load_use_tnew0", RUN);
    nxt(); hz.e_tnew = 2'd1; hz.d_rs_tuse = 2'd1;
    expect_out("tnew_eq_tuse", RUN);
    nxt(); hz.e_tnew = 2'd2; hz.d_rs_tuse = TUSE_NONE;
    expect_out("tuse_none", RUN);

    // M stage, rt path, and register 0.
    nxt(); idle(); hz.d_rt_addr = 5'd9; hz.d_rt_tuse = 2'd1; hz.m_wa = 5'd9; hz.m_tnew = 2'd1;
    expect_out("m_tnew_eq", RUN);
    nxt(); hz.m_tnew = 2'd2;
    expect_out("m_tnew_gt", STALL);
    nxt(); hz.d_rt_addr = 5'd0; hz.e_wa = 5'd0; hz.e_tnew = 2'd2;
    expect_out("reg0_never", RUN);
    nxt(); idle(); hz.d_rt_addr = 5'd9; hz.d_rt_tuse = 2'd1; hz.e_wa = 5'd9; hz.e_tnew = 2'd2;
    expect_out("rt_e_stall", STALL);

    // Mult sequencing with a held md consumer.
    nxt(); idle(); hz.d_is_md = 1'b1; hz.e_md_start = 1'b1; hz.e_md_op = MD_OP_MULT;
    expect_out("mult_t0", STALL);
    for (int i = 1; i <= 5; i++) begin
      nxt(); hz.e_md_start = 1'b0;
      expect_out($sformatf("mult_t%0d", i), STALL_MD);
    end
    nxt();
    expect_out("mult_t6", RUN);

    // Div, then a reset in the middle of the count.
    nxt(); idle(); hz.e_md_start = 1'b1; hz.e_md_op = MD_OP_DIV;
    expect_out("div_t0", RUN);
    for (int i = 1; i <= 3; i++) begin
      nxt(); hz.e_md_start = 1'b0;
      expect_out($sformatf("div_t%0d", i), RUN_BUSY);
    end
    nxt(); reset = 1'b1;
    expect_out("div_reset_t4", RUN);
    nxt(); reset = 1'b0;
    expect_out("div_after_reset_t5", RUN);
    nxt();
    expect_out("div_after_reset_t6", RUN);

    // A fresh div reloads the full count.
    nxt(); hz.e_md_start = 1'b1; hz.e_md_op = MD_OP_DIV;
    expect_out("div2_t0", RUN);
    for (int i = 1; i <= 10; i++) begin
      nxt(); hz.e_md_start = 1'b0;
      expect_out($sformatf("div2_t%0d", i), RUN_BUSY);
    end
    nxt();
    expect_out("div2_t11", RUN);

    // Register and md hazards together still give one stall. Removing the
    // register hazard leaves the md stall in place.
    nxt(); idle(); hz.e_md_start = 1'b1; hz.e_md_op = MD_OP_MULT;
    expect_out("both_t0", RUN);
    nxt(); hz.e_md_start = 1'b0; hz.d_is_md = 1'b1; rs_load_use();
    expect_out("both_t1", STALL_MD);
    for (int i = 2; i <= 5; i++) begin
      nxt(); hz.d_rs_addr = 5'd0; hz.e_wa = 5'd0;
      expect_out($sformatf("md_only_t%0d", i), STALL_MD);
    end
    nxt();
    expect_out("md_only_t6", RUN);

`ifdef STALL_STAT_EN
    // Seven stall cycles after reset give a count of seven.
    nxt(); idle(); reset = 1'b1;
    nxt(); reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rs_load_use();
      nxt();
    end
    idle();
    #1;
    vectors++;
    assert (stall_cnt === 32'd7) else begin
      miscompares++;
      $error("FAIL stall_cnt_seven observed=%0d expected=7", stall_cnt);
    end
`endif

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline stall controller for the five-stage MIPS core. It produces the PC write enable, the F/D register write enable and the D/E register clear. It compares D-stage operand demand (Tuse) against E/M-stage result availability (Tnew). It also owns the multiply/divide busy timer that serialises HI/LO instructions behind an in-flight mult/div.

## Interface
Parameters:
- MULT_CYCLES, default 5, busy cycles after a mult/multu start.
- DIV_CYCLES, default 10, busy cycles after a div/divu start.
- CNT_W, default 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- d_rs_addr  input  5  D-stage rs register number.
- d_rt_addr  input  5  D-stage rt register number.
- d_rs_tuse  input  2  cycles until rs is consumed; 3 = not used.
- d_rt_tuse  input  2  cycles until rt is consumed; 3 = not used.
- d_is_md  input  1  D-stage instruction uses the md unit (mult/div/mfhi/mflo/mthi/mtlo).
- e_wa  input  5  E-stage destination register; 0 = none.
- e_tnew  input  2  cycles until the E-stage result is forwardable.
- m_wa  input  5  M-stage destination register; 0 = none.
- m_tnew  input  2  cycles until the M-stage result is forwardable.
- e_md_start  input  1  E-stage instruction is mult/div in its first E cycle (one-cycle pulse).
- e_md_op  input  1  0 = mult class, 1 = div class; valid with e_md_start.
- pc_we  output  1  drives the PC WE input.
- fd_we  output  1  F/D pipeline register write enable.
- de_clr  output  1  D/E pipeline register clear (bubble insert).
- md_busy  output  1  md unit computing.
- stall_cnt  output  32  stall-cycle count; exists only under STALL_STAT_EN.

## Operation
- rs_stall = (d_rs_addr != 0) && ((d_rs_addr == e_wa && e_tnew > d_rs_tuse) || (d_rs_addr == m_wa && m_tnew > d_rs_tuse)).
- rt_stall is the same expression using d_rt_addr and d_rt_tuse.
- Tuse = 3 never stalls, because Tnew is at most 2. Register 0 never stalls.
- md_stall = d_is_md && (md_busy || e_md_start).
- stall = rs_stall | rt_stall | md_stall.
- Outputs: pc_we = fd_we = ~stall; de_clr = stall.
- Busy timer (register md_cnt):
  - On e_md_start while md_cnt == 0, md_cnt loads MULT_CYCLES or DIV_CYCLES according to e_md_op.
  - Otherwise md_cnt decrements while nonzero.
  - md_busy = (md_cnt != 0).
- e_md_start while md_cnt != 0 is ignored and the count continues. The stall logic makes this unreachable; the verifier should flag it as an assertion.
- While reset is high, outputs are forced to pc_we = 1, fd_we = 1, de_clr = 0 and md_busy = 0, regardless of inputs.

## Timing
- Hazard outputs are combinational from the current-cycle inputs, with no latency.
- md_cnt is registered. For a mult start pulse in cycle t:
  - md_busy is high in cycles t+1 through t+5 and low in t+6.
  - A D-stage md instruction stalls in cycles t through t+5, and advances in t+6.
- For a div start pulse in cycle t, md_busy is high in t+1 through t+10.
- Reset at any cycle, including mid-count, gives md_cnt = 0 (and stall_cnt = 0) at the next edge.
- Reset takes priority over e_md_start in the same cycle.
- Simultaneous register and md stalls still produce a single stall cycle; the outputs are an OR, not additive.

## Configuration
- STALL_STAT_EN defined:
  - The stall_cnt port and its 32-bit register exist.
  - The register increments on every posedge where stall = 1 and reset = 0, and wraps from 0xFFFFFFFF to 0.
- STALL_STAT_EN undefined:
  - The port and the register are absent.
  - All other behaviour is identical.

## Structure
- These belong in const.v:
  - `TUSE_NONE (2'd3).
  - `MD_MULT_CYCLES (5) and `MD_DIV_CYCLES (10), used as the parameter defaults.
  - `MD_OP_MULT / `MD_OP_DIV encodings.
- Sub-module md_busy_timer holds md_cnt and the md_busy generation.
- The top level holds the hazard comparators, the output mux and the optional stall counter.

## Test plan
- Load-use: d_rs_addr=8, d_rs_tuse=0, e_wa=8, e_tnew=2 -> pc_we=0, fd_we=0, de_clr=1. Then change to e_tnew=0 -> no stall.
- M-stage and register 0: d_rt_addr=9, d_rt_tuse=1, m_wa=9, m_tnew=1 -> no stall. With m_tnew=2 -> stall. With d_rt_addr=0 and e_wa=0, e_tnew=2 -> no stall.
- Mult sequencing: e_md_start=1, e_md_op=0 at cycle t; d_is_md=1 held -> stall in t..t+5; md_busy high t+1..t+5; pc_we=1 at t+6.
- Div plus mid-count reset: div start at t; reset at t+4 -> md_busy=0 from t+5. A later start reloads to 10.
- Simultaneous hazards: rs load-use together with md_busy -> single stall. Remove the rs hazard -> stall persists until md_cnt reaches 0.
- STALL_STAT_EN build: 7 stall cycles after reset -> stall_cnt=7. Preload 0xFFFFFFFF then one stall -> stall_cnt=0.
